// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter, one bit per txclk cycle, DEPTH-entry word FIFO.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                     txclk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         tx_data,
  input  logic                     ld_tx_data,
  input  logic                     clr_overflow,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic                     tx_full,
  output logic                     tx_empty,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     tx_done,
  output logic                     tx_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t           state_q, state_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_nxt;
  logic [WIDTH-1:0] head_c;
  logic             wr_en_c, pop_c;
  logic             tx_out_nxt, busy_nxt, done_nxt;
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  // Full is judged before the edge, so a same-edge pop never makes room for a write
  assign wr_en_c = ld_tx_data && !tx_full;
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge txclk) begin
    if (wr_en_c) mem[wr_ptr] <= tx_data;
  end

  always_comb begin
    level_nxt = fifo_level;
    case ({wr_en_c, pop_c})
      2'b10:   level_nxt = fifo_level + LW'(1);
      2'b01:   level_nxt = fifo_level - LW'(1);
      default: level_nxt = fifo_level;
    endcase
  end

  // FIFO pointers, occupancy flags and sticky overflow
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      tx_full     <= 1'b0;
      tx_empty    <= 1'b1;
      tx_overflow <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)   rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_nxt;
      tx_full    <= (level_nxt == LW'(DEPTH));
      tx_empty   <= (level_nxt == '0);
      if (ld_tx_data && tx_full) tx_overflow <= 1'b1;
      else if (clr_overflow)     tx_overflow <= 1'b0;
    end
  end

  // State register and frame datapath
  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (pop_c)                  sh_q <= head_c;
      else if (state_nxt == S_DATA) sh_q <= sh_q >> 1;
`ifdef UART_TX_PARITY_EN
      if (pop_c) par_q <= ^head_c;
`endif
    end
  end

  // Next state; cnt counts data bits in DATA and stop bits in STOP
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pop_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          pop_c     = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        state_nxt = S_DATA;
        cnt_nxt   = '0;
      end
      S_DATA: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        state_nxt = S_STOP;
        cnt_nxt   = '0;
      end
`endif
      S_STOP: begin
        if (cnt_q == CW'(STOP_BITS - 1)) begin
          cnt_nxt = '0;
          if (!tx_empty) begin
            pop_c     = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, registered below so tx_out is glitch-free
  always_comb begin
    tx_out_nxt = 1'b1;
    busy_nxt   = (state_nxt != S_IDLE);
    done_nxt   = (state_nxt == S_STOP) && (cnt_nxt == CW'(STOP_BITS - 1));
    case (state_nxt)
      S_START:  tx_out_nxt = 1'b0;
      S_DATA:   tx_out_nxt = sh_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out_nxt = par_q;
`endif
      default:  tx_out_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_out  <= tx_out_nxt;
      tx_busy <= busy_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: two instances (1 and 2 stop bits) on shared inputs, checked every cycle
// against a queue-level model of the FIFO and the serial line.
module tb_uart_tx_fifo;

  localparam int W     = 18;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int VW    = 6 + LW;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          txclk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  tx_data;
  logic          ld_tx_data, clr_overflow;
  logic          s0_out, s0_busy, s0_full, s0_empty, s0_done, s0_ovf;
  logic          s1_out, s1_busy, s1_full, s1_empty, s1_done, s1_ovf;
  logic [LW-1:0] s0_level, s1_level;

  int checks = 0;
  int errors = 0;

  // Model: per instance a word queue (array + count) and the frame on the line as a bit vector
  logic [W-1:0]  m_fifo  [2][DEPTH];
  int            m_cnt   [2];
  logic [63:0]   m_frame [2];
  int            m_rem   [2];
  logic          m_ovf   [2];

  always #5 txclk = ~txclk;

  uart_tx_fifo #(.WIDTH(W), .DEPTH(DEPTH), .STOP_BITS(1)) u_dut1 (
    .txclk(txclk), .reset_n(reset_n), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .clr_overflow(clr_overflow), .tx_out(s0_out), .tx_busy(s0_busy), .tx_full(s0_full),
    .tx_empty(s0_empty), .fifo_level(s0_level), .tx_done(s0_done), .tx_overflow(s0_ovf));

  uart_tx_fifo #(.WIDTH(W), .DEPTH(DEPTH), .STOP_BITS(2)) u_dut2 (
    .txclk(txclk), .reset_n(reset_n), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .clr_overflow(clr_overflow), .tx_out(s1_out), .tx_busy(s1_busy), .tx_full(s1_full),
    .tx_empty(s1_empty), .fifo_level(s1_level), .tx_done(s1_done), .tx_overflow(s1_ovf));

  function automatic int frame_len(input int i);
    return 1 + W + P + (i + 1);
  endfunction

  // {tx_out, tx_busy, tx_done, tx_full, tx_empty, tx_overflow, fifo_level}
  function automatic logic [VW-1:0] obs(input int i);
    logic [VW-1:0] v;
    if (i == 0) v = {s0_out, s0_busy, s0_done, s0_full, s0_empty, s0_ovf, s0_level};
    else        v = {s1_out, s1_busy, s1_done, s1_full, s1_empty, s1_ovf, s1_level};
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int i);
    logic o;
    o = (m_rem[i] > 0) ? m_frame[i][0] : 1'b1;
    return {o, m_rem[i] > 0, m_rem[i] == 1, m_cnt[i] == DEPTH, m_cnt[i] == 0, m_ovf[i],
            LW'(m_cnt[i])};
  endfunction

  function automatic logic [VW-1:0] reset_vec();
    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, LW'(0)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_rem[i] = 0; m_ovf[i] = 1'b0; m_frame[i] = '0;
    end
  endtask

  // One clock edge: finish the current line bit, start a frame if the line is free, then enqueue
  task automatic model_edge(input logic ld, input logic [W-1:0] d, input logic clr);
    for (int i = 0; i < 2; i++) begin
      bit pre_full, pre_ne;
      logic [W-1:0] w;
      pre_full = (m_cnt[i] == DEPTH);
      pre_ne   = (m_cnt[i] > 0);
      if (m_rem[i] > 0) begin
        m_frame[i] = m_frame[i] >> 1;
        m_rem[i]--;
      end
      if (m_rem[i] == 0 && pre_ne) begin
        w = m_fifo[i][0];
        for (int k = 0; k < DEPTH - 1; k++) m_fifo[i][k] = m_fifo[i][k+1];
        m_cnt[i]--;
        m_frame[i] = '1;
        m_frame[i][0] = 1'b0;
        for (int k = 0; k < W; k++) m_frame[i][1+k] = w[k];
        if (P == 1) m_frame[i][1+W] = ^w;
        m_rem[i] = frame_len(i);
      end
      if (ld && pre_full) m_ovf[i] = 1'b1;
      else if (clr)       m_ovf[i] = 1'b0;
      if (ld && !pre_full) begin
        m_fifo[i][m_cnt[i]] = d;
        m_cnt[i]++;
      end
    end
  endtask

  task automatic tick(input logic ld, input logic [W-1:0] d, input logic clr);
    ld_tx_data = ld; tx_data = d; clr_overflow = clr;
    @(posedge txclk);
    model_edge(ld, d, clr);
    #1;
    ld_tx_data = 1'b0; clr_overflow = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ld_tx_data = 1'b0; clr_overflow = 1'b0; tx_data = '0;
    model_reset();
    repeat (2) @(posedge txclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== reset_vec()) begin
        errors++;
        $display("FAIL reset inst%0d got=%h exp=%h", i, obs(i), reset_vec());
      end
    end
    @(negedge txclk);
    reset_n = 1'b1;
    tick(1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL reset_release inst%0d got=%h exp=%h", i, obs(i), exp_vec(i));
      end
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] seq, exp_seq;
    logic [VW-1:0] v;
    int n;
    int dones [2];
    logic prev_done [2];
    seq = '0; n = 0;
    dones[0] = 0; dones[1] = 0; prev_done[0] = 1'b0; prev_done[1] = 1'b0;
    if (P == 1) exp_seq = 32'({1'b1, 1'b1, 18'h2A5C3, 1'b0});
    else        exp_seq = 32'({1'b1, 18'h2A5C3, 1'b0});
    for (int c = 0; c < 30; c++) begin
      tick(c == 0, 18'h2A5C3, 1'b0);
      for (int i = 0; i < 2; i++) begin
        v = obs(i);
        checks++;
        if (v !== exp_vec(i)) begin
          errors++;
          $display("FAIL single_frame inst%0d cyc%0d got=%h exp=%h", i, c, v, exp_vec(i));
        end
        if (prev_done[i]) begin
          checks++;
          if (v[VW-2] !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_done inst%0d got=%b exp=0", i, v[VW-2]);
          end
        end
        prev_done[i] = v[VW-3];
        if (v[VW-3]) dones[i]++;
      end
      if (s0_busy && n < 32) begin
        seq[n] = s0_out;
        n++;
      end
    end
    checks++;
    if (seq !== exp_seq || n != frame_len(0)) begin
      errors++;
      $display("FAIL frame_bits got=%h/%0d exp=%h/%0d", seq, n, exp_seq, frame_len(0));
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dones[i] != 1) begin
        errors++;
        $display("FAIL done_count inst%0d got=%0d exp=1", i, dones[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [4];
    logic [VW-1:0] v;
    int seen [2], gaps [2], dn [2];
    bit full_seen;
    words[0] = 18'h3FFFF;
    for (int k = 1; k < 4; k++) words[k] = W'($urandom);
    full_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin seen[i] = 0; gaps[i] = 0; dn[i] = 0; end
    for (int c = 0; c < 104; c++) begin
      tick(c < 4, (c < 4) ? words[c] : '0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        v = obs(i);
        checks++;
        if (v !== exp_vec(i)) begin
          errors++;
          $display("FAIL back_to_back inst%0d cyc%0d got=%h exp=%h", i, c, v, exp_vec(i));
        end
        if (v[VW-4]) full_seen = 1'b1;
        if (v[VW-2]) seen[i] = 1;
        else if (seen[i] == 1 && dn[i] < 4) gaps[i]++;
        if (v[VW-3]) dn[i]++;
      end
    end
    checks++;
    if (full_seen) begin
      errors++;
      $display("FAIL b2b_full got=1 exp=0");
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (gaps[i] != 0 || dn[i] != 4) begin
        errors++;
        $display("FAIL b2b_gaps inst%0d got gaps=%0d frames=%0d exp gaps=0 frames=4", i, gaps[i], dn[i]);
      end
    end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 126; c++) begin
      // c 0..4: w0 plus four fills; c 5: dropped; c 6: dropped with clear; c 7: clear only
      tick(c <= 6, W'($urandom), c == 6 || c == 7);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL overflow inst%0d cyc%0d got=%h exp=%h", i, c, obs(i), exp_vec(i));
        end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if ({s0_ovf, s1_ovf, s0_full} !== 3'b111) begin
          errors++;
          $display("FAIL ovf_set cyc%0d got=%b exp=111", c, {s0_ovf, s1_ovf, s0_full});
        end
      end
      if (c == 7) begin
        checks++;
        if ({s0_ovf, s1_ovf} !== 2'b00) begin
          errors++;
          $display("FAIL ovf_clear got=%b exp=00", {s0_ovf, s1_ovf});
        end
      end
    end
  endtask

  task automatic test_write_pop();
    int c;
    for (int k = 0; k < 3; k++) tick(1'b1, W'($urandom), 1'b0);
    c = 0;
    while (c < 40 && m_rem[0] != 1) begin
      tick(1'b0, '0, 1'b0);
      c++;
    end
    checks++;
    if (m_rem[0] != 1 || s0_level !== LW'(2)) begin
      errors++;
      $display("FAIL write_pop_setup got level=%0d rem=%0d exp level=2 rem=1", s0_level, m_rem[0]);
    end
    tick(1'b1, W'($urandom), 1'b0);
    checks++;
    if (s0_level !== LW'(2)) begin
      errors++;
      $display("FAIL write_pop_level got=%0d exp=2", s0_level);
    end
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL write_pop inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_vec(i));
        end
      end
      tick(1'b0, '0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    tick(1'b1, W'($urandom), 1'b0);
    tick(1'b1, W'($urandom), 1'b0);
    c = 0;
    while (c < 20 && m_rem[0] != frame_len(0) - 8) begin
      tick(1'b0, '0, 1'b0);
      c++;
    end
    checks++;
    if (m_rem[0] != frame_len(0) - 8 || s0_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup got busy=%b rem=%0d exp busy=1 rem=%0d", s0_busy, m_rem[0], frame_len(0) - 8);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== reset_vec()) begin
        errors++;
        $display("FAIL reset_mid inst%0d got=%h exp=%h", i, obs(i), reset_vec());
      end
    end
    @(negedge txclk);
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, '0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL after_reset inst%0d cyc%0d got=%h exp=%h", i, k, obs(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_random();
    logic ld;
    for (int c = 0; c < 720; c++) begin
      if (c < 300)      ld = ($urandom_range(0, 99) < 70);
      else if (c < 600) ld = ($urandom_range(0, 99) < 12);
      else              ld = 1'b0;
      tick(ld, W'($urandom), $urandom_range(0, 19) == 0);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d got=%h exp=%h", i, c, obs(i), exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_write_pop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter for the serial readout path. It generalises the single-word transmitter in four ways: the word width is configurable, a DEPTH-entry FIFO accepts words while a frame is in flight, frames can use 1 or 2 stop bits, and queued words go out back-to-back. An even-parity bit can be compiled in. The block runs entirely on the baud-rate clock txclk, one bit per cycle, and feeds the existing 16x-oversampling receiver on the link partner.

## Interface
- WIDTH, 18: data bits per frame (1..32).
- DEPTH, 4: FIFO entries; power of two, at least 2.
- STOP_BITS, 1: stop bits per frame (1 or 2).

- txclk  in  1  baud-rate clock; one bit period per cycle.
- reset_n  in  1  reset, asynchronous, active-low.
- tx_data  in  WIDTH  word to enqueue.
- ld_tx_data  in  1  enqueue strobe, sampled every rising edge of txclk.
- clr_overflow  in  1  clears tx_overflow.
- tx_out  out  1  serial line; idles high.
- tx_busy  out  1  high while a frame is on the line.
- tx_full  out  1  FIFO holds DEPTH words.
- tx_empty  out  1  FIFO holds 0 words.
- fifo_level  out  $clog2(DEPTH)+1  number of queued words (excludes the word being sent).
- tx_done  out  1  one-cycle pulse in the last stop-bit cycle of each frame.
- tx_overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

## Operation
- Reset values: tx_out=1, tx_busy=0, tx_full=0, tx_empty=1, fifo_level=0, tx_done=0, tx_overflow=0. FIFO pointers go to 0 and the FSM goes to IDLE.
- Frame order: start bit (0), tx_data[0] through tx_data[WIDTH-1] (LSB first), parity bit if compiled in, then STOP_BITS stop bits (1).
- Frame length is 1+WIDTH+P+STOP_BITS cycles, where P=1 with parity and 0 without.
- FIFO write: on an edge with ld_tx_data=1 and tx_full=0, tx_data is written.
- Write while full: the word is dropped and tx_overflow is set. A pop on the same edge does not make room; tx_full is evaluated before the edge.
- Simultaneous write and pop when not full: both happen and fifo_level is unchanged.
- clr_overflow clears tx_overflow on the next edge. If it coincides with a dropped write, set wins.
- FSM states:
  - IDLE: tx_out=1. If the FIFO is not empty, pop into the shift register and go to START.
  - START: tx_out=0, go to DATA.
  - DATA: shift out WIDTH bits using a bit counter of $clog2(WIDTH) bits, then go to PARITY (if compiled in) or STOP.
  - PARITY: tx_out = XOR of the word (even parity), go to STOP.
  - STOP: tx_out=1 for STOP_BITS cycles. In the last stop cycle: pulse tx_done; if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- tx_busy is 1 in START, DATA, PARITY and STOP, and 0 only in IDLE.
- A word is latched into the shift register at pop time. Later FIFO writes never corrupt the frame in flight.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous), the FIFO contents are discarded, and the partial frame is truncated.

## Timing
- All outputs are registered; tx_out is glitch-free.
- Latency from an idle, empty block: ld_tx_data sampled at edge N, FIFO written at N, pop at N+1, tx_out falls after N+1. That is 2 edges from strobe to start bit.
- Bit k of the data (0-based) is driven during cycle 2+k after the write edge.
- Back-to-back words: the start bit of word n+1 directly follows the last stop bit of word n, with zero idle cycles.
- tx_full and fifo_level update on the edge that changes occupancy.
- tx_done is high for exactly one cycle per frame and coincides with the final stop bit.

## Configuration
- UART_TX_PARITY_EN defined: frames include the even-parity bit; frame = WIDTH+2+STOP_BITS cycles.
- UART_TX_PARITY_EN undefined: no parity state or logic; frame = WIDTH+1+STOP_BITS cycles.
- The receiver build must use the same setting.

## Test plan
- Reset, then one word 18'h2A5C3 with parity enabled and STOP_BITS=1:
  - tx_out sequence: 0, 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1,0,1, parity 1, stop 1 (21 cycles).
  - tx_done pulses once; tx_busy falls the cycle after.
- Write 4 words on consecutive edges (DEPTH=4): tx_full never asserts, because the first word pops at the second edge. The 4 frames go out contiguously with no idle bits between them, and tx_busy stays high throughout.
- Fill 4 words while a frame is in flight, then write a 5th: the 5th is dropped, tx_overflow=1, and the 4 queued words arrive intact. clr_overflow returns tx_overflow to 0.
- Write and pop on the same edge at fifo_level=2: fifo_level stays 2 and no word is lost.
- Assert reset_n low during data bit 7: tx_out goes to 1 immediately, tx_busy=0, fifo_level=0. After release, no residual frame is transmitted.
- STOP_BITS=2 with parity compiled out, word 18'h3FFFF:
  - frame = 0, eighteen 1s, 1,1 (21 cycles);
  - the next start bit follows immediately if another word is queued.
